// File: rtl/seq_approx_mult.sv
// Iterative tiled approximate multiplier: one 4x4 digit product per clock, result after (WIDTH/4)^2 cycles.
// Result is held in DONE until out_ready; optional ZERO_SKIP_EN shortcuts zero operands to a 1-cycle result.
module seq_approx_mult #(
  parameter int WIDTH      = 8,
  parameter int TRUNC_BITS = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [3:0]           approx_lvl,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   r
);

  localparam int N  = WIDTH / 4;
  localparam int IW = $clog2(N);
  localparam logic [7:0] TRUNC_MASK = 8'hFF << TRUNC_BITS;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state;
  logic [WIDTH-1:0]     a_q;
  logic [WIDTH-1:0]     b_q;
  logic [3:0]           lvl_q;
  logic [IW-1:0]        di;
  logic [IW-1:0]        dj;
  logic [2*WIDTH-1:0]   acc;

  logic [WIDTH-1:0]     a_sh;
  logic [WIDTH-1:0]     b_sh;
  logic [7:0]           prod;
  logic [7:0]           prod_t;
  logic [4:0]           sig;
  logic [2*WIDTH-1:0]   addend;
  logic [2*WIDTH-1:0]   sum;
  logic                 last_tile;
  logic                 zero_skip;

  always_comb begin
    a_sh      = a_q >> {di, 2'b00};
    b_sh      = b_q >> {dj, 2'b00};
    prod      = {4'b0, a_sh[3:0]} * {4'b0, b_sh[3:0]};
    sig       = {{(5-IW){1'b0}}, di} + {{(5-IW){1'b0}}, dj};
    // Low-significance tiles (i+j below the level) lose their bottom TRUNC_BITS bits.
    prod_t    = (sig < {1'b0, lvl_q}) ? (prod & TRUNC_MASK) : prod;
    addend    = {{(2*WIDTH-8){1'b0}}, prod_t} << {sig, 2'b00};
    sum       = acc + addend;
    last_tile = (di == IW'(N-1)) && (dj == IW'(N-1));
`ifdef ZERO_SKIP_EN
    zero_skip = (a_q == '0) || (b_q == '0);
`else
    zero_skip = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      r         <= '0;
      acc       <= '0;
      di        <= '0;
      dj        <= '0;
      a_q       <= '0;
      b_q       <= '0;
      lvl_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            lvl_q    <= approx_lvl;
            acc      <= '0;
            di       <= '0;
            dj       <= '0;
            in_ready <= 1'b0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (zero_skip) begin
            r         <= '0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            acc <= sum;
            if (last_tile) begin
              r         <= sum;
              out_valid <= 1'b1;
              di        <= '0;
              dj        <= '0;
              state     <= DONE;
            end else if (dj == IW'(N-1)) begin
              dj <= '0;
              di <= di + 1'b1;
            end else begin
              dj <= dj + 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
